// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: valid/ready pipeline stage register with a 2-entry skid
// buffer. Carries an opaque DATA_W payload; the bubble flag is implied by
// out_valid. The "ready" seen upstream is registered (it is ~skid_valid), so
// there is no combinational path from out_ready back to in_ready.
//
// Optional feature: define PIPE_STAGE_PERF_EN to add saturating stall/bubble
// counters (stall_cnt, bubble_cnt) of width CNT_W.
module pipe_stage_elastic #(
   parameter int DATA_W      = 96,
   parameter bit BUBBLE_ZERO = 1'b1,
   parameter int CNT_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              out_valid,
   output logic              out_bubble,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_ready,
   input  logic              flush
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  bubble_cnt
`endif
);

   // Occupancy: EMPTY (no entries), ONE (main only), FULL (main + skid).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   logic              main_valid;
   logic              skid_valid;
   logic              in_ready_q;
   logic [DATA_W-1:0] main_data;
   logic [DATA_W-1:0] skid_data;
   logic              acc;
   logic              pop;

   // Parameter sanity at elaboration time.
   if (DATA_W < 1) begin : g_bad_data_w
      $error("pipe_stage_elastic: DATA_W must be >= 1");
   end
   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("pipe_stage_elastic: CNT_W must be >= 1");
   end

   // Handshake qualifiers; both depend only on registered flags plus the
   // partner's request line.
   assign acc = in_valid & in_ready_q;
   assign pop = main_valid & out_ready;

   // Occupancy FSM with registered flags; flush overrides every transition.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready_q <= 1'b1;
      end else if (flush) begin
         state      <= EMPTY;
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
         in_ready_q <= 1'b1;
      end else begin
         case (state)
            EMPTY: begin
               if (acc) begin
                  state      <= ONE;
                  main_valid <= 1'b1;
               end
            end
            ONE: begin
               if (acc && !pop) begin
                  state      <= FULL;
                  skid_valid <= 1'b1;
                  in_ready_q <= 1'b0;
               end else if (!acc && pop) begin
                  state      <= EMPTY;
                  main_valid <= 1'b0;
               end
            end
            FULL: begin
               if (pop) begin
                  state      <= ONE;
                  skid_valid <= 1'b0;
                  in_ready_q <= 1'b1;
               end
            end
            default: begin
               state      <= EMPTY;
               main_valid <= 1'b0;
               skid_valid <= 1'b0;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

   // Payload movement. Flush leaves the data registers alone; the valid
   // flags already mark them dead and BUBBLE_ZERO masks the output.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         main_data <= '0;
         skid_data <= '0;
      end else if (!flush) begin
         // Head is loaded from the input when the stage is (or becomes)
         // empty of older entries, otherwise from the skid on a pop.
         if (acc && (!main_valid || pop))
            main_data <= in_data;
         else if (pop && skid_valid)
            main_data <= skid_data;
         // Input lands in the skid only when the head is held this cycle.
         if (acc && main_valid && !pop)
            skid_data <= in_data;
      end
   end

   assign in_ready   = in_ready_q;
   assign out_valid  = main_valid;
   assign out_bubble = ~main_valid;

   if (BUBBLE_ZERO) begin : g_bubble_zero
      assign out_data = main_valid ? main_data : '0;
   end else begin : g_bubble_hold
      assign out_data = main_data;
   end

`ifdef PIPE_STAGE_PERF_EN
   // Saturating performance counters; only reset clears them, not flush.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (main_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (!main_valid && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end
`endif

endmodule
